// File: rtl/pcie_route_nxm.sv
// pcie_route_nxm: drains NUM_IN first-word-fall-through ingress FIFOs with a
// round-robin arbiter. Each word is routed by its destination field into one of
// NUM_OUT internal FWFT egress FIFOs.
//
// Ports:
//   clk, reset (async, active-low)
//   in_data/in_empty/in_pop  : ingress heads, empty flags, one-hot pop (comb)
//   out_pop                  : consumer pop per egress FIFO
//   out_data                 : egress FIFO head words (0 while empty)
//   out_empty/out_full/out_almost_full/out_almost_empty : registered flags
//   out_error                : sticky overflow/underflow per egress FIFO
//   pause                    : OR of almost_full flags, stalls ingress
//   route_err                : sticky, a word with an out-of-range destination was dropped
module pcie_route_nxm #(
    parameter int unsigned NUM_IN   = 2,
    parameter int unsigned NUM_OUT  = 2,
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = 3,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [NUM_IN-1:0]         in_empty,
    output logic [NUM_IN-1:0]         in_pop,
    input  logic [NUM_OUT-1:0]        out_pop,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_empty,
    output logic [NUM_OUT-1:0]        out_full,
    output logic [NUM_OUT-1:0]        out_almost_full,
    output logic [NUM_OUT-1:0]        out_almost_empty,
    output logic [NUM_OUT-1:0]        out_error,
    output logic                      pause,
    output logic                      route_err
);

    localparam int unsigned SEL_W = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1;
    localparam int unsigned IN_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;
    localparam int unsigned IDX_W = IN_W + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [IN_W-1:0]    rr_ptr;
    logic [IN_W-1:0]    grant;
    logic               grant_vld;
    logic               pop_vld;
    logic [DATA_W-1:0]  word;
    logic [SEL_W-1:0]   dest;
    logic               dest_ok;
    logic [NUM_OUT-1:0] push;

    // Pause is taken straight from the registered almost_full flags.
    assign pause = |out_almost_full;

    // Round-robin search: first non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        logic [IDX_W-1:0] sum;
        sum       = '0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            sum = {1'b0, rr_ptr} + IDX_W'(k);
            if (sum >= IDX_W'(NUM_IN)) begin
                sum = sum - IDX_W'(NUM_IN);
            end
            if (!grant_vld && !in_empty[IN_W'(sum)]) begin
                grant_vld = 1'b1;
                grant     = IN_W'(sum);
            end
        end
    end

    // Reset gating keeps ingress untouched while reset is held.
    assign pop_vld = grant_vld & ~pause & reset;
    assign in_pop  = pop_vld ? (NUM_IN'(1'b1) << grant) : '0;

    // Select the granted head word and decode its destination field.
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant == IN_W'(i)) begin
                word = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign dest    = word[DATA_W-1 -: SEL_W];
    assign dest_ok = (32'(dest) < NUM_OUT);

    always_comb begin
        push = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            push[j] = pop_vld && dest_ok && (dest == SEL_W'(j));
        end
    end

    // Arbiter pointer and sticky routing error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            route_err <= 1'b0;
        end else begin
            if (pop_vld) begin
                rr_ptr <= (grant == IN_W'(NUM_IN - 1)) ? '0 : IN_W'(grant + 1'b1);
                if (!dest_ok) begin
                    route_err <= 1'b1;
                end
            end
        end
    end

    // Egress FIFOs: circular buffers with flags registered from the next count.
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  cnt;
        logic [CNT_W-1:0]  cnt_nxt;
        logic              empty_q;
        logic              full_q;
        logic              af_q;
        logic              ae_q;
        logic              err_q;
        logic              push_ok;
        logic              pop_ok;

        assign push_ok = push[j] & ~full_q;
        assign pop_ok  = out_pop[j] & ~empty_q;

        always_comb begin
            cnt_nxt = cnt;
            case ({push_ok, pop_ok})
                2'b10:   cnt_nxt = cnt + 1'b1;
                2'b01:   cnt_nxt = cnt - 1'b1;
                default: cnt_nxt = cnt;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                cnt     <= '0;
                empty_q <= 1'b1;
                full_q  <= 1'b0;
                af_q    <= 1'b0;
                ae_q    <= 1'b1;
                err_q   <= 1'b0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= PTR_W'(wr_ptr + 1'b1);
                end
                if (pop_ok) begin
                    rd_ptr <= PTR_W'(rd_ptr + 1'b1);
                end
                cnt     <= cnt_nxt;
                empty_q <= (cnt_nxt == '0);
                full_q  <= (cnt_nxt == CNT_W'(DEPTH));
                af_q    <= (cnt_nxt >= CNT_W'(AF_LEVEL));
                ae_q    <= (cnt_nxt <= CNT_W'(AE_LEVEL));
                if ((push[j] && full_q) || (out_pop[j] && empty_q)) begin
                    err_q <= 1'b1;
                end
            end
        end

        // Storage needs no reset; the empty flag masks stale contents.
        always_ff @(posedge clk) begin
            if (push_ok) begin
                mem[wr_ptr] <= word;
            end
        end

        assign out_data[j*DATA_W +: DATA_W] = empty_q ? '0 : mem[rd_ptr];
        assign out_empty[j]        = empty_q;
        assign out_full[j]         = full_q;
        assign out_almost_full[j]  = af_q;
        assign out_almost_empty[j] = ae_q;
        assign out_error[j]        = err_q;
    end

endmodule

// File: tb/tb_pcie_route_nxm.sv
// Scoreboard bench for pcie_route_nxm: directed stimulus pushes the expected
// word into a per-egress queue; a negedge monitor pops and compares.
module tb_pcie_route_nxm;

    localparam int unsigned DW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // Default instance (2 in, 2 out)
    logic [2*DW-1:0] in_data  = '0;
    logic [1:0]      in_empty = 2'b11;
    logic [1:0]      in_pop;
    logic [1:0]      out_pop  = 2'b00;
    logic [2*DW-1:0] out_data;
    logic [1:0]      out_empty, out_full, out_af, out_ae, out_err;
    logic            pause, route_err;

    // Three-output instance for the out-of-range destination case
    logic [2*DW-1:0] in_data3  = '0;
    logic [1:0]      in_empty3 = 2'b11;
    logic [1:0]      in_pop3;
    logic [2:0]      out_pop3  = 3'b000;
    logic [3*DW-1:0] out_data3;
    logic [2:0]      out_empty3, out_full3, out_af3, out_ae3, out_err3;
    logic            pause3, route_err3;

    pcie_route_nxm u_dut (
        .clk(clk), .reset(rst),
        .in_data(in_data), .in_empty(in_empty), .in_pop(in_pop),
        .out_pop(out_pop), .out_data(out_data), .out_empty(out_empty),
        .out_full(out_full), .out_almost_full(out_af), .out_almost_empty(out_ae),
        .out_error(out_err), .pause(pause), .route_err(route_err)
    );

    pcie_route_nxm #(.NUM_OUT(3)) u_dut3 (
        .clk(clk), .reset(rst),
        .in_data(in_data3), .in_empty(in_empty3), .in_pop(in_pop3),
        .out_pop(out_pop3), .out_data(out_data3), .out_empty(out_empty3),
        .out_full(out_full3), .out_almost_full(out_af3), .out_almost_empty(out_ae3),
        .out_error(out_err3), .pause(pause3), .route_err(route_err3)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] mon_w;
    logic [1:0]    exp_pop = 2'b00;
    bit            mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] w);
        if (w[DW-1]) q1.push_back(w);
        else         q0.push_back(w);
    endtask

    // One cycle of stimulus; exp is the hand-computed in_pop for this cycle.
    task automatic step(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [1:0] emp, input logic [1:0] opop, input logic [1:0] exp);
        @(posedge clk); #1;
        in_data  = {d1, d0};
        in_empty = emp;
        out_pop  = opop;
        exp_pop  = exp;
        if (exp[0]) push_exp(d0);
        if (exp[1]) push_exp(d1);
    endtask

    // Monitor: check in_pop and every accepted consumer pop against the queues.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            check("in_pop", 32'(in_pop), 32'(exp_pop));
            if (out_pop[0] && !out_empty[0]) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out0_data: got %0h expected none", out_data[DW-1:0]);
                end else begin
                    mon_w = q0.pop_front();
                    check("out0_data", 32'(out_data[DW-1:0]), 32'(mon_w));
                end
            end
            if (out_pop[1] && !out_empty[1]) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out1_data: got %0h expected none", out_data[2*DW-1:DW]);
                end else begin
                    mon_w = q1.pop_front();
                    check("out1_data", 32'(out_data[2*DW-1:DW]), 32'(mon_w));
                end
            end
        end
    end

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_empty = 2'b00;
        in_data  = {10'h2CC, 10'h0EE};
        #1;
        check("rst_out_empty", 32'(out_empty), 32'h3);
        check("rst_out_ae", 32'(out_ae), 32'h3);
        check("rst_out_af", 32'(out_af), 32'h0);
        check("rst_out_full", 32'(out_full), 32'h0);
        check("rst_out_err", 32'(out_err), 32'h0);
        check("rst_pause", 32'(pause), 32'h0);
        check("rst_route_err", 32'(route_err), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_in_pop", 32'(in_pop), 32'h0);
        @(posedge clk); #1;
        in_empty = 2'b11;
        exp_pop  = 2'b00;
        rst      = 1'b1;
        mon_en   = 1'b1;

        // Single-input routing: 2FF on channel 0 goes to out1
        step(10'h2FF, 10'h000, 2'b10, 2'b00, 2'b01);
        step(10'h000, 10'h000, 2'b11, 2'b00, 2'b00);
        check("single_out_empty", 32'(out_empty), 32'h1);
        check("single_out1_data", 32'(out_data[2*DW-1:DW]), 32'h2FF);
        check("single_out0_data", 32'(out_data[DW-1:0]), 32'h0);
        step(10'h000, 10'h000, 2'b11, 2'b10, 2'b00);
        step(10'h000, 10'h000, 2'b11, 2'b00, 2'b00);
        check("single_drained", 32'(out_empty), 32'h3);

        // Round-robin: rr pointer sits at 1 after the single grant to channel 0
        step(10'h0EE, 10'h2CC, 2'b00, 2'b00, 2'b10);
        step(10'h0EE, 10'h2CC, 2'b00, 2'b00, 2'b01);
        step(10'h0EE, 10'h2CC, 2'b00, 2'b00, 2'b10);
        step(10'h0EE, 10'h2CC, 2'b00, 2'b00, 2'b01);
        step(10'h000, 10'h000, 2'b11, 2'b00, 2'b00);
        check("rr_out_empty", 32'(out_empty), 32'h0);
        check("rr_out_ae", 32'(out_ae), 32'h0);
        check("rr_out_af", 32'(out_af), 32'h0);
        step(10'h000, 10'h000, 2'b11, 2'b11, 2'b00);
        step(10'h000, 10'h000, 2'b11, 2'b11, 2'b00);
        step(10'h000, 10'h000, 2'b11, 2'b00, 2'b00);
        check("rr_drained", 32'(out_empty), 32'h3);

        // Backpressure: three words to out0 raise pause
        step(10'h011, 10'h000, 2'b10, 2'b00, 2'b01);
        step(10'h012, 10'h000, 2'b10, 2'b00, 2'b01);
        step(10'h013, 10'h000, 2'b10, 2'b00, 2'b01);
        step(10'h014, 10'h000, 2'b10, 2'b00, 2'b00);
        check("bp_pause_on", 32'(pause), 32'h1);
        check("bp_out_af", 32'(out_af), 32'h1);
        step(10'h014, 10'h000, 2'b10, 2'b01, 2'b00);
        check("bp_pause_held", 32'(pause), 32'h1);
        step(10'h014, 10'h000, 2'b10, 2'b00, 2'b01);
        check("bp_pause_off", 32'(pause), 32'h0);
        step(10'h000, 10'h000, 2'b11, 2'b01, 2'b00);
        step(10'h000, 10'h000, 2'b11, 2'b01, 2'b00);
        step(10'h000, 10'h000, 2'b11, 2'b01, 2'b00);
        step(10'h000, 10'h000, 2'b11, 2'b00, 2'b00);
        check("bp_drained", 32'(out_empty), 32'h3);
        check("bp_no_err", 32'(out_err), 32'h0);

        // Underflow on out1 sets a sticky error and leaves the count at 0
        step(10'h000, 10'h000, 2'b11, 2'b10, 2'b00);
        step(10'h000, 10'h000, 2'b11, 2'b00, 2'b00);
        check("uf_err", 32'(out_err), 32'h2);
        check("uf_empty", 32'(out_empty), 32'h3);
        check("uf_ae", 32'(out_ae), 32'h3);
        step(10'h000, 10'h000, 2'b11, 2'b00, 2'b00);
        check("uf_err_sticky", 32'(out_err), 32'h2);

        // Wrap-around: ten words through out0 with a concurrent pop
        step(10'h001, 10'h000, 2'b10, 2'b00, 2'b01);
        for (int k = 2; k <= 10; k++) begin
            step(DW'(k), 10'h000, 2'b10, 2'b01, 2'b01);
            check("wrap_not_empty", 32'(out_empty[0]), 32'h0);
            check("wrap_ae", 32'(out_ae[0]), 32'h1);
        end
        step(10'h000, 10'h000, 2'b11, 2'b01, 2'b00);
        step(10'h000, 10'h000, 2'b11, 2'b00, 2'b00);
        check("wrap_empty", 32'(out_empty), 32'h3);
        check("wrap_err", 32'(out_err), 32'h2);
        check("route_err_main", 32'(route_err), 32'h0);

        // Reset mid-traffic with two words buffered in out0
        step(10'h021, 10'h000, 2'b10, 2'b00, 2'b01);
        step(10'h022, 10'h000, 2'b10, 2'b00, 2'b01);
        step(10'h000, 10'h000, 2'b11, 2'b00, 2'b00);
        check("mid_pre_empty", 32'(out_empty), 32'h2);
        check("mid_pre_ae", 32'(out_ae), 32'h2);
        @(posedge clk); #1;
        in_empty = 2'b00;
        in_data  = {10'h2CC, 10'h0EE};
        exp_pop  = 2'b00;
        rst      = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("mid_empty", 32'(out_empty), 32'h3);
        check("mid_ae", 32'(out_ae), 32'h3);
        check("mid_data", 32'(out_data), 32'h0);
        check("mid_err", 32'(out_err), 32'h0);
        check("mid_pause", 32'(pause), 32'h0);
        check("mid_in_pop", 32'(in_pop), 32'h0);
        @(posedge clk); #1;
        check("mid_in_pop_held", 32'(in_pop), 32'h0);
        in_empty = 2'b11;
        rst      = 1'b1;
        step(10'h000, 10'h000, 2'b11, 2'b00, 2'b00);
        check("mid_after_empty", 32'(out_empty), 32'h3);

        // Out-of-range destination on the three-output instance
        @(posedge clk); #1;
        check("dest3_route_err_pre", 32'(route_err3), 32'h0);
        in_data3  = {10'h000, 10'h3AB};
        in_empty3 = 2'b10;
        #1;
        check("dest3_in_pop", 32'(in_pop3), 32'h1);
        @(posedge clk); #1;
        in_empty3 = 2'b11;
        check("dest3_route_err", 32'(route_err3), 32'h1);
        check("dest3_out_empty", 32'(out_empty3), 32'h7);
        check("dest3_out_err", 32'(out_err3), 32'h0);
        @(posedge clk); #1;
        check("dest3_route_err_sticky", 32'(route_err3), 32'h1);

        check("sb_q0_left", 32'(q0.size()), 32'h0);
        check("sb_q1_left", 32'(q1.size()), 32'h0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_route_nxm.md
Name: pcie_route_nxm

Overview:
- Parametrised successor to the fixed two-input/two-output routing stage of the PCIe switch.
- Drains NUM_IN upstream first-word-fall-through (FWFT) FIFOs using round-robin arbitration.
- Reads a destination field from each word and pushes the word into one of NUM_OUT internal egress FIFOs.
- Each egress FIFO reports full/empty/almost flags and a sticky error; a global pause throttles the ingress side.

Parameters:
- NUM_IN, 2, number of ingress channels (2..8).
- NUM_OUT, 2, number of egress FIFOs (2..8).
- DATA_W, 10, word width including the destination field.
- DEPTH, 4, entries per egress FIFO (power of two, >=4).
- AF_LEVEL, 3, almost_full asserted when count >= AF_LEVEL (AF_LEVEL <= DEPTH-1).
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL.
- Derived: SEL_W = max(1, clog2(NUM_OUT)); CNT_W = clog2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  NUM_IN*DATA_W  head word of each ingress FIFO; channel i occupies bits [i*DATA_W +: DATA_W].
- in_empty  in  NUM_IN  ingress FIFO i is empty.
- in_pop  out  NUM_IN  one-hot pop to ingress FIFO i (combinational).
- out_pop  in  NUM_OUT  consumer pop of egress FIFO j.
- out_data  out  NUM_OUT*DATA_W  FWFT head word of egress FIFO j.
- out_empty  out  NUM_OUT  egress FIFO j is empty.
- out_full  out  NUM_OUT  egress FIFO j count == DEPTH.
- out_almost_full  out  NUM_OUT  count >= AF_LEVEL.
- out_almost_empty  out  NUM_OUT  count <= AE_LEVEL.
- out_error  out  NUM_OUT  sticky: push while full, or pop while empty.
- pause  out  1  OR of all out_almost_full.
- route_err  out  1  sticky: word with destination >= NUM_OUT was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - all counts, read/write pointers and the arbiter pointer clear to 0.
  - out_empty=all 1; out_almost_empty=all 1.
  - out_full, out_almost_full, out_error, pause, route_err, in_pop all 0.
  - out_data reads as 0.
  - Reset may assert mid-traffic; all stored words are discarded.
- Arbitration (combinational from registered state):
  - Eligible when pause==0 and at least one in_empty bit is 0.
  - Grant goes to the first non-empty channel at or after rr_ptr, searching upward with wrap-around.
  - in_pop[grant]=1; at most one in_pop bit high per cycle.
  - On a grant, rr_ptr <= grant+1 modulo NUM_IN. rr_ptr holds when there is no grant.
- Routing:
  - dest = in_data[grant][DATA_W-1 -: SEL_W]. The full word, destination bits included, is stored.
  - If dest < NUM_OUT: push into FIFO dest at the same clock edge as the pop.
  - Otherwise: the word is popped and discarded; route_err <= 1.
- Latency:
  - The word is visible on out_data[dest] with out_empty[dest]=0 one cycle after the pop cycle.
  - Throughput is one word per cycle aggregate.
- Egress FIFO:
  - Circular buffer; pointers wrap from DEPTH-1 to 0.
  - A pop with out_empty=1 is ignored and sets out_error[j].
  - A push with out_full=1 is dropped and sets out_error[j]. This cannot occur while pause works, but it must be handled.
  - Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
  - Simultaneous push and pop on an empty FIFO: the push succeeds, the pop errors.
  - All flags are registered and derived from the next count.
- Pause:
  - Combinational OR of the registered almost_full flags.
  - No ingress pop occurs in any cycle where pause==1.
  - Consumer pops continue during pause; pause drops the cycle after count falls below AF_LEVEL.
- Error flags stay at 1 until reset.

Test Plan:
- Reset mid-traffic: assert reset with 2 words buffered in out0 -> all outputs immediately at reset values; out_empty=2'b11; no in_pop while reset=0.
- Single-input routing (NUM_IN=2, NUM_OUT=2, DATA_W=10, DEPTH=4):
  - Channel 0 presents 10'h2FF (dest 1) for 1 cycle -> in_pop=2'b01.
  - Next cycle: out_data[1]=10'h2FF, out_empty=2'b01, out0 unaffected.
- Round-robin fairness: both inputs non-empty every cycle, channel 0 word 10'h0EE, channel 1 word 10'h2CC -> in_pop alternates 01,10,01,10; out0 and out1 each receive one word every 2 cycles.
- Backpressure:
  - Push 3 words to out0, no consumer -> out_almost_full[0]=1 and pause=1 after the 3rd push; no further in_pop.
  - Pop one from out0 -> pause=0 the next cycle, then ingress resumes.
- Error cases:
  - Pop out1 while empty -> out_error[1]=1 and stays 1; count stays 0.
  - With NUM_OUT=3, in_data dest field 2'b11 -> word popped, no FIFO changes, route_err=1.
- Wrap-around: stream 10 words 10'h001..10'h00A to out0 with a concurrent pop each cycle -> words exit in order, count never exceeds 1, pointers wrap, no error.
